// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
// Covers the FSM state encoding and the sizing of the bit counter.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter must hold the values 0..w, so it needs clog2(w+1) bits.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_serial_shift_reg.sv
// Right-shifting register with a parallel load and a serial input at the MSB.
// Works as a PISO when its LSB is used, or as a SIPO when its parallel output is used.
module bit_serial_shift_reg #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic         i_shift_en,
    input  logic         i_ser_in,
    output logic [N-1:0] o_data
);

    logic [N-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_val;
        end else if (i_shift_en) begin
            r_data <= {i_ser_in, r_data[N-1:1]};
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/bit_serial_add_sequencer.sv
// Feeds sign-extended operands LSB-first into an external bit-serial adder and
// collects the serial sum into a W+1-bit parallel result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on the FSM state, never on in_valid. out_valid and
// out_sum stay constant until the edge on which out_ready is sampled high.
module bit_serial_add_sequencer
    import bit_serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         add_reset,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum,
    output state_t       dbg_state
);

    localparam int CNT_W = cnt_w(W);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_shift;
    logic [W:0]       w_sa;
    logic [W:0]       w_sb;
    logic [W:0]       w_sum;
    logic             w_unused;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_shift  = (r_state == SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_reset = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                add_reset = 1'b0;
                // The edge with the counter at W captures the sign bit of the sum.
                if (r_cnt == CNT_W'(W)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    bit_serial_shift_reg #(.N(W + 1)) u_sa (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val ({in_a[W-1], in_a}),
        .i_shift_en (w_shift),
        .i_ser_in   (1'b0),
        .o_data     (w_sa)
    );

    bit_serial_shift_reg #(.N(W + 1)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val ({in_b[W-1], in_b}),
        .i_shift_en (w_shift),
        .i_ser_in   (1'b0),
        .o_data     (w_sb)
    );

    // Sum bits enter at the MSB, so after W+1 shifts the first bit sits at bit 0.
    bit_serial_shift_reg #(.N(W + 1)) u_sum (
        .clk        (clk),
        .reset      (reset),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_shift_en (w_shift),
        .i_ser_in   (ser_x),
        .o_data     (w_sum)
    );

    assign ser_a     = w_shift & w_sa[0];
    assign ser_b     = w_shift & w_sb[0];
    assign out_sum   = w_sum;
    assign dbg_state = r_state;
    assign w_unused  = ^{w_sa[W:1], w_sb[W:1]};

endmodule

// File: tb/tb_bit_serial_add_sequencer.sv
// Directed bench for bit_serial_add_sequencer with a behavioural bit-serial adder.
// Drives and samples on the falling clock edge.
module tb_bit_serial_add_sequencer;
    import bit_serial_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         add_reset;
    logic         ser_a;
    logic         ser_b;
    logic         ser_x;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    state_t       dbg_state;

    int n_pass   = 0;
    int n_checks = 0;

    bit_serial_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_reset (add_reset),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_x     (ser_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Bit-serial full adder: combinational sum, registered carry cleared by add_reset.
    logic r_carry;
    always_ff @(posedge clk) begin
        if (add_reset) r_carry <= 1'b0;
        else           r_carry <= (ser_a & ser_b) | (ser_a & r_carry) | (ser_b & r_carry);
    end
    assign ser_x = ser_a ^ ser_b ^ r_carry;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] exp, input string tag, input bit chk_lat);
        int lat;
        accept(a, b);
        wait_valid(lat);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp));
        if (chk_lat) check({tag, "_lat"}, lat, 10);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int lat;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_add_reset", add_reset, 1);
        check("rst_ser_ab", {ser_a, ser_b}, 0);
        check("rst_out_sum", out_sum, 0);
        reset = 1'b0;
        @(negedge clk);

        // 3 + 4 with a cycle-accurate timeline.
        in_a = 8'd3; in_b = 8'd4; in_valid = 1'b1;
        check("t1_in_ready_c0", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_ser_ab_c1", {ser_a, ser_b}, 2'b10);
        cnt = 0;
        repeat (9) begin
            if (add_reset === 1'b0 && out_valid === 1'b0 && in_ready === 1'b0) cnt++;
            @(negedge clk);
        end
        check("t1_shift_cycles", cnt, 9);
        check("t1_out_valid_c10", out_valid, 1);
        check("t1_out_sum", out_sum, 9'h007);
        check("t1_add_reset_c10", add_reset, 1);
        check("t1_in_ready_c10", in_ready, 0);
        @(negedge clk);
        check("t1_in_ready_c11", in_ready, 1);
        check("t1_out_valid_c11", out_valid, 0);

        run_op(8'h80, 8'h80, 9'h100, "neg128x2", 1'b1);
        run_op(8'h7F, 8'h7F, 9'h0FE, "pos127x2", 1'b1);
        run_op(8'hFB, 8'h03, 9'h1FE, "m5p3", 1'b1);
        run_op(8'h00, 8'hFF, 9'h1FF, "zm1", 1'b1);

        for (int ai = -8; ai <= 7; ai++) begin
            for (int bi = -8; bi <= 7; bi++) begin
                run_op(8'(ai), 8'(bi), 9'(ai + bi), "sweep", 1'b0);
            end
        end

        // Backpressure: 50 + (-70) = -20.
        out_ready = 1'b0;
        accept(8'd50, 8'hBA);
        wait_valid(lat);
        check("bp_lat", lat, 10);
        repeat (5) begin
            check("bp_sum", out_sum, 9'h1EC);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_add_reset", add_reset, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("bp_sum_release", out_sum, 9'h1EC);
        @(negedge clk);
        check("bp_out_valid_after", out_valid, 0);
        check("bp_in_ready_after", in_ready, 1);

        // in_valid held through SHIFT with new operands, then accepted back-to-back.
        in_a = 8'd10; in_b = 8'd20; in_valid = 1'b1;
        @(negedge clk);
        in_a = 8'd55; in_b = 8'd66;
        wait_valid(lat);
        check("hold_lat", lat, 10);
        check("hold_sum", out_sum, 9'h01E);
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_state", 32'(dbg_state), 32'(SHIFT));
        wait_valid(lat);
        check("b2b_lat", lat, 10);
        check("b2b_sum", out_sum, 9'h079);
        @(negedge clk);

        // Reset after 4 shift edges of 100 + 27.
        accept(8'd100, 8'd27);
        repeat (4) @(negedge clk);
        check("mid_state", 32'(dbg_state), 32'(SHIFT));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_state", 32'(dbg_state), 32'(IDLE));
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_add_reset", add_reset, 1);
        check("mrst_out_sum", out_sum, 0);
        run_op(8'd1, 8'd1, 9'h002, "after_rst", 1'b1);

        // Reset while the carry is set (-1 + 1), then a clean add.
        accept(8'hFF, 8'h01);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_op(8'd1, 8'd1, 9'h002, "carry_clr", 1'b1);

        // Reset together with in_valid: no accept.
        reset = 1'b1; in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        check("rstv_state", 32'(dbg_state), 32'(IDLE));
        check("rstv_in_ready", in_ready, 1);
        @(negedge clk);
        check("rstv_still_idle", 32'(dbg_state), 32'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
